// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit
// Combined control decode, ALU-control decode and ALU for the RV32IM core.
// Every output is registered: values presented with in_valid=1 appear on
// the outputs one cycle later. With in_valid=0 the outputs hold their
// previous values while out_valid drops to 0.
//
// Optional feature: define EXEC_MULDIV_EN to decode and execute the
// M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) as single-cycle
// logic. Without it, R-type funct7=0000001 is flagged illegal and no
// multiply/divide hardware is built.
//
// Handshake: in_valid qualifies the inputs on the rising clk edge; there is
// no ready, every cycle may carry a new operation; out_valid is in_valid
// delayed by one cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid                   input capture qualifier
//   opcode, funct3, funct7     instruction fields
//   pc, rs1_val, rs2_val, imm  operands
//   out_valid                  registered in_valid
//   reg_write .. auipc         control strobes
//   alu_op                     class (00 add, 01 branch, 10 R, 11 I)
//   alu_ctrl                   ALU operation code
//   result, zero, branch_taken ALU/link result and flags
//   illegal                    unsupported opcode or function
module exec_ctrl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    output logic        out_valid,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        jump,
    output logic        jump_r,
    output logic        mem_to_reg,
    output logic        auipc,
    output logic [1:0]  alu_op,
    output logic [4:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        branch_taken,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_NE   = 5'd10;
    localparam logic [4:0] ALU_LT   = 5'd11;
    localparam logic [4:0] ALU_GE   = 5'd12;
    localparam logic [4:0] ALU_LTU  = 5'd13;
    localparam logic [4:0] ALU_GEU  = 5'd14;
`ifdef EXEC_MULDIV_EN
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;
`endif

    // ---------------------------------------------------------------
    // Main control decode
    // ---------------------------------------------------------------
    logic       d_reg_write, d_alu_src, d_mem_read, d_mem_write;
    logic       d_branch, d_jump, d_jump_r, d_mem_to_reg, d_auipc;
    logic [1:0] d_alu_op;
    logic       d_is_lui;
    logic       op_illegal;

    always_comb begin
        d_reg_write  = 1'b0;
        d_alu_src    = 1'b0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_branch     = 1'b0;
        d_jump       = 1'b0;
        d_jump_r     = 1'b0;
        d_mem_to_reg = 1'b0;
        d_auipc      = 1'b0;
        d_alu_op     = 2'b00;
        d_is_lui     = 1'b0;
        op_illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                d_reg_write = 1'b1;
                d_alu_op    = 2'b10;
            end
            OP_I: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_alu_op    = 2'b11;
            end
            OP_LOAD: begin
                d_reg_write  = 1'b1;
                d_alu_src    = 1'b1;
                d_mem_read   = 1'b1;
                d_mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                d_branch = 1'b1;
                d_alu_op = 2'b01;
            end
            OP_JAL: begin
                d_reg_write = 1'b1;
                d_jump      = 1'b1;
            end
            OP_JALR: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_jump_r    = 1'b1;
            end
            OP_LUI: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_is_lui    = 1'b1;
            end
            OP_AUIPC: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
                d_auipc     = 1'b1;
            end
            default: op_illegal = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------
    // ALU-control decode
    // ---------------------------------------------------------------
    // Shared R/I funct3 map; sra_sel picks the arithmetic right shift.
    function automatic logic [4:0] base_code(input logic [2:0] f3, input logic sra_sel);
        logic [4:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    logic [4:0] c_alu_ctrl;
    logic       fn_illegal;

    always_comb begin
        c_alu_ctrl = ALU_ADD;
        fn_illegal = 1'b0;
        case (d_alu_op)
            2'b01: begin
                // Each branch code yields 0 exactly when the branch is taken.
                case (funct3)
                    3'b000:  c_alu_ctrl = ALU_SUB;
                    3'b001:  c_alu_ctrl = ALU_NE;
                    3'b100:  c_alu_ctrl = ALU_LT;
                    3'b101:  c_alu_ctrl = ALU_GE;
                    3'b110:  c_alu_ctrl = ALU_LTU;
                    3'b111:  c_alu_ctrl = ALU_GEU;
                    default: fn_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                case (funct7)
                    7'b0000000: c_alu_ctrl = base_code(funct3, 1'b0);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      c_alu_ctrl = ALU_SUB;
                        else if (funct3 == 3'b101) c_alu_ctrl = ALU_SRA;
                        else                       fn_illegal = 1'b1;
                    end
                    7'b0000001: begin
`ifdef EXEC_MULDIV_EN
                        c_alu_ctrl = {2'b10, funct3};
`else
                        fn_illegal = 1'b1;
`endif
                    end
                    default: fn_illegal = 1'b1;
                endcase
            end
            2'b11:   c_alu_ctrl = base_code(funct3, funct7[5]);
            default: c_alu_ctrl = ALU_ADD;
        endcase
    end

    // ---------------------------------------------------------------
    // Operand muxing and ALU
    // ---------------------------------------------------------------
    logic [31:0] op_a, op_b;
    logic        lt_s, lt_u;

    assign op_a = d_auipc  ? pc    :
                  d_is_lui ? 32'd0 : rs1_val;
    assign op_b = d_alu_src ? imm : rs2_val;
    assign lt_s = $signed(op_a) < $signed(op_b);
    assign lt_u = op_a < op_b;

`ifdef EXEC_MULDIV_EN
    // One 64x64 multiplier on sign- or zero-extended operands covers all
    // four multiply flavours; the low 64 bits are exact in every case.
    logic        mul_a_sgn, mul_b_sgn;
    logic [63:0] mul_a64, mul_b64, mul_p;
    assign mul_a_sgn = (c_alu_ctrl == ALU_MULH) || (c_alu_ctrl == ALU_MULHSU);
    assign mul_b_sgn = (c_alu_ctrl == ALU_MULH);
    assign mul_a64   = {{32{mul_a_sgn & op_a[31]}}, op_a};
    assign mul_b64   = {{32{mul_b_sgn & op_b[31]}}, op_b};
    assign mul_p     = mul_a64 * mul_b64;

    // Divisors are replaced by 1 in the corner cases so the dividers never
    // see /0 or INT_MIN/-1; the corner results are muxed in afterwards.
    logic        div_b_zero, div_ovf;
    logic [31:0] div_b_s, div_b_u, quot_s, quot_u, rem_s, rem_u;
    assign div_b_zero = (op_b == 32'd0);
    assign div_ovf    = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign div_b_s    = (div_b_zero || div_ovf) ? 32'd1 : op_b;
    assign div_b_u    = div_b_zero ? 32'd1 : op_b;
    assign quot_s     = $signed(op_a) / $signed(div_b_s);
    assign rem_s      = $signed(op_a) % $signed(div_b_s);
    assign quot_u     = op_a / div_b_u;
    assign rem_u      = op_a % div_b_u;
`endif

    logic [31:0] alu_y;

    always_comb begin
        alu_y = 32'd0;
        case (c_alu_ctrl)
            ALU_ADD:  alu_y = op_a + op_b;
            ALU_SUB:  alu_y = op_a - op_b;
            ALU_SLL:  alu_y = op_a << op_b[4:0];
            ALU_SLT:  alu_y = {31'd0, lt_s};
            ALU_SLTU: alu_y = {31'd0, lt_u};
            ALU_XOR:  alu_y = op_a ^ op_b;
            ALU_SRL:  alu_y = op_a >> op_b[4:0];
            ALU_SRA:  alu_y = $signed(op_a) >>> op_b[4:0];
            ALU_OR:   alu_y = op_a | op_b;
            ALU_AND:  alu_y = op_a & op_b;
            ALU_NE:   alu_y = {31'd0, op_a == op_b};
            ALU_LT:   alu_y = {31'd0, ~lt_s};
            ALU_GE:   alu_y = {31'd0, lt_s};
            ALU_LTU:  alu_y = {31'd0, ~lt_u};
            ALU_GEU:  alu_y = {31'd0, lt_u};
`ifdef EXEC_MULDIV_EN
            ALU_MUL:    alu_y = mul_p[31:0];
            ALU_MULH:   alu_y = mul_p[63:32];
            ALU_MULHSU: alu_y = mul_p[63:32];
            ALU_MULHU:  alu_y = mul_p[63:32];
            ALU_DIV:    alu_y = div_b_zero ? 32'hFFFF_FFFF :
                                div_ovf    ? 32'h8000_0000 : quot_s;
            ALU_DIVU:   alu_y = div_b_zero ? 32'hFFFF_FFFF : quot_u;
            ALU_REM:    alu_y = div_b_zero ? op_a :
                                div_ovf    ? 32'd0 : rem_s;
            ALU_REMU:   alu_y = div_b_zero ? op_a : rem_u;
`endif
            default:  alu_y = 32'd0;
        endcase
    end

    // ---------------------------------------------------------------
    // Final selection; an illegal operation clears everything else.
    // ---------------------------------------------------------------
    logic        fin_illegal;
    logic [31:0] nxt_result;

    assign fin_illegal = op_illegal | fn_illegal;
    assign nxt_result  = fin_illegal            ? 32'd0 :
                         (d_jump | d_jump_r)    ? pc + 32'd4 : alu_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            reg_write    <= 1'b0;
            alu_src      <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            branch       <= 1'b0;
            jump         <= 1'b0;
            jump_r       <= 1'b0;
            mem_to_reg   <= 1'b0;
            auipc        <= 1'b0;
            alu_op       <= 2'b00;
            alu_ctrl     <= 5'd0;
            result       <= 32'd0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                reg_write    <= d_reg_write  & ~fin_illegal;
                alu_src      <= d_alu_src    & ~fin_illegal;
                mem_read     <= d_mem_read   & ~fin_illegal;
                mem_write    <= d_mem_write  & ~fin_illegal;
                branch       <= d_branch     & ~fin_illegal;
                jump         <= d_jump       & ~fin_illegal;
                jump_r       <= d_jump_r     & ~fin_illegal;
                mem_to_reg   <= d_mem_to_reg & ~fin_illegal;
                auipc        <= d_auipc      & ~fin_illegal;
                alu_op       <= fin_illegal ? 2'b00 : d_alu_op;
                alu_ctrl     <= fin_illegal ? 5'd0  : c_alu_ctrl;
                result       <= nxt_result;
                zero         <= (nxt_result == 32'd0);
                branch_taken <= d_branch & ~fin_illegal & (nxt_result == 32'd0);
                illegal      <= fin_illegal;
            end
        end
    end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Testbench for exec_ctrl_unit. Honours EXEC_MULDIV_EN the same way as the
// design so either build can be checked.
module tb_exec_ctrl_unit;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic        out_valid, reg_write, alu_src, mem_read, mem_write;
    logic        branch, jump, jump_r, mem_to_reg, auipc;
    logic [1:0]  alu_op;
    logic [4:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero, branch_taken, illegal;

    exec_ctrl_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
        .out_valid(out_valid), .reg_write(reg_write), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .jump(jump), .jump_r(jump_r), .mem_to_reg(mem_to_reg), .auipc(auipc),
        .alu_op(alu_op), .alu_ctrl(alu_ctrl), .result(result), .zero(zero),
        .branch_taken(branch_taken), .illegal(illegal)
    );

    localparam int W = 52;
    logic [W-1:0] obs;
    assign obs = {out_valid, reg_write, alu_src, mem_read, mem_write, branch,
                  jump, jump_r, mem_to_reg, auipc, alu_op, alu_ctrl, result,
                  zero, branch_taken, illegal};

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_hold;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void arith(input logic [2:0] f3, input logic alt,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [4:0] ctl, output logic [31:0] res);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'd0: begin ctl = 5'd0; res = a + b; end
            3'd1: begin ctl = 5'd2; res = a << b[4:0]; end
            3'd2: begin ctl = 5'd3; res = (sa < sb) ? 32'd1 : 32'd0; end
            3'd3: begin ctl = 5'd4; res = (a < b) ? 32'd1 : 32'd0; end
            3'd4: begin ctl = 5'd5; res = a ^ b; end
            3'd5: begin
                if (alt) begin ctl = 5'd7; res = sa >>> b[4:0]; end
                else     begin ctl = 5'd6; res = a >> b[4:0]; end
            end
            3'd6: begin ctl = 5'd8; res = a | b; end
            default: begin ctl = 5'd9; res = a & b; end
        endcase
    endfunction

`ifdef EXEC_MULDIV_EN
    function automatic void muldiv(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output logic [4:0] ctl, output logic [31:0] res);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        ctl = 5'd16 + 5'(f3);
        case (f3)
            3'd0: begin p = 64'(sa * sb); res = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); res = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; res = p[63:32]; end
            3'd4: begin
                if (b == 0) res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
                else res = ia / ib;
            end
            3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
                else res = ia % ib;
            end
            default: res = (b == 0) ? a : a % b;
        endcase
    endfunction
`endif

    function automatic logic [W-1:0] model(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] pcv,
                                           input logic [31:0] r1, input logic [31:0] r2,
                                           input logic [31:0] im);
        logic rw, src, mr, mw, br, jp, jr, m2r, au, ill;
        logic [1:0]  aop;
        logic [4:0]  ctl;
        logic [31:0] res;
        int s1, s2;
        s1 = $signed(r1);
        s2 = $signed(r2);
        {rw, src, mr, mw, br, jp, jr, m2r, au, ill} = '0;
        aop = 2'd0;
        ctl = 5'd0;
        res = 32'd0;
        case (op)
            7'h33: begin
                rw = 1; aop = 2'd2;
                if (f7 == 7'h00) arith(f3, 1'b0, r1, r2, ctl, res);
                else if (f7 == 7'h20 && f3 == 3'd0) begin ctl = 5'd1; res = r1 - r2; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin ctl = 5'd7; res = s1 >>> r2[4:0]; end
`ifdef EXEC_MULDIV_EN
                else if (f7 == 7'h01) muldiv(f3, r1, r2, ctl, res);
`endif
                else ill = 1;
            end
            7'h13: begin rw = 1; src = 1; aop = 2'd3; arith(f3, f7[5], r1, im, ctl, res); end
            7'h03: begin rw = 1; src = 1; mr = 1; m2r = 1; res = r1 + im; end
            7'h23: begin src = 1; mw = 1; res = r1 + im; end
            7'h63: begin
                br = 1; aop = 2'd1;
                case (f3)
                    3'd0: begin ctl = 5'd1;  res = r1 - r2; end
                    3'd1: begin ctl = 5'd10; res = (r1 != r2) ? 0 : 1; end
                    3'd4: begin ctl = 5'd11; res = (s1 <  s2) ? 0 : 1; end
                    3'd5: begin ctl = 5'd12; res = (s1 >= s2) ? 0 : 1; end
                    3'd6: begin ctl = 5'd13; res = (r1 <  r2) ? 0 : 1; end
                    3'd7: begin ctl = 5'd14; res = (r1 >= r2) ? 0 : 1; end
                    default: ill = 1;
                endcase
            end
            7'h6F: begin rw = 1; jp = 1; res = pcv + 4; end
            7'h67: begin rw = 1; src = 1; jr = 1; res = pcv + 4; end
            7'h37: begin rw = 1; src = 1; res = im; end
            7'h17: begin rw = 1; src = 1; au = 1; res = pcv + im; end
            default: ill = 1;
        endcase
        if (ill) begin
            {rw, src, mr, mw, br, jp, jr, m2r, au} = '0;
            aop = 2'd0; ctl = 5'd0; res = 32'd0;
        end
        return {1'b1, rw, src, mr, mw, br, jp, jr, m2r, au, aop, ctl, res,
                res == 32'd0, br && (res == 32'd0), ill};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] pcv, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im, input logic v);
        opcode = op; funct3 = f3; funct7 = f7; pc = pcv;
        rs1_val = r1; rs2_val = r2; imm = im; in_valid = v;
    endtask

    // Advance one edge, update the expected output state and compare.
    task automatic step();
        if (!rst && in_valid)
            exp_q.push_back(model(opcode, funct3, funct7, pc, rs1_val, rs2_val, imm));
        @(posedge clk);
        #1;
        if (rst) exp_hold = '0;
        else if (in_valid) exp_hold = exp_q.pop_front();
        else exp_hold[W-1] = 1'b0;
        check("scb", 64'(obs), 64'(exp_hold));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [6:0] rnd_op();
        logic [6:0] ops [9];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        if ($urandom_range(0, 15) == 0) return 7'($urandom);
        return ops[$urandom_range(0, 8)];
    endfunction

    function automatic logic [6:0] rnd_f7();
        case ($urandom_range(0, 4))
            0, 1: return 7'h00;
            2: return 7'h20;
            3: return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        exp_hold = '0;
        drive(7'h33, 3'd0, 7'h00, 32'd0, 32'd1, 32'd2, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check("rst_vec", 64'(obs), 64'd0);
        rst = 1'b0;

        // R ADD
        drive(7'h33, 3'd0, 7'h00, 32'h40, 32'd5, 32'd7, 32'd0, 1'b1);
        step();
        check("add_res", 64'(result), 64'd12);
        check("add_rw",  64'(reg_write), 64'd1);
        check("add_aop", 64'(alu_op), 64'd2);
        check("add_ctl", 64'(alu_ctrl), 64'd0);
        check("add_ov",  64'(out_valid), 64'd1);

        // idle cycle: outputs hold, out_valid drops
        drive(7'h63, 3'd1, 7'h00, 32'd0, 32'd3, 32'd4, 32'd0, 1'b0);
        step();
        check("hold_res", 64'(result), 64'd12);
        check("hold_ov",  64'(out_valid), 64'd0);

        // BNE taken / not taken
        drive(7'h63, 3'd1, 7'h00, 32'd0, 32'd3, 32'd4, 32'd0, 1'b1);
        step();
        check("bne_res", 64'(result), 64'd0);
        check("bne_zero", 64'(zero), 64'd1);
        check("bne_tk", 64'(branch_taken), 64'd1);
        drive(7'h63, 3'd1, 7'h00, 32'd0, 32'd4, 32'd4, 32'd0, 1'b1);
        step();
        check("bne_ntk", 64'(branch_taken), 64'd0);

        // SRAI
        drive(7'h13, 3'd5, 7'h20, 32'd0, 32'h8000_0000, 32'd0, 32'h404, 1'b1);
        step();
        check("srai", 64'(result), 64'hF800_0000);

        // AUIPC, LUI
        drive(7'h17, 3'd0, 7'h00, 32'h100, 32'h55, 32'd0, 32'h1000, 1'b1);
        step();
        check("auipc_res", 64'(result), 64'h1100);
        check("auipc_flag", 64'(auipc), 64'd1);
        drive(7'h37, 3'd0, 7'h00, 32'h100, 32'h55, 32'd0, 32'hABCD_E000, 1'b1);
        step();
        check("lui_res", 64'(result), 64'hABCD_E000);

        // JAL link
        drive(7'h6F, 3'd0, 7'h00, 32'h200, 32'h9, 32'h9, 32'h30, 1'b1);
        step();
        check("jal_link", 64'(result), 64'h204);

        // M extension (or illegal without it)
        drive(7'h33, 3'd4, 7'h01, 32'd0, 32'd7, 32'd0, 32'd0, 1'b1);
        step();
`ifdef EXEC_MULDIV_EN
        check("div0", 64'(result), 64'hFFFF_FFFF);
        drive(7'h33, 3'd6, 7'h01, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);
        step();
        check("rem_ovf", 64'(result), 64'd0);
        drive(7'h33, 3'd3, 7'h01, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b1);
        step();
        check("mulhu", 64'(result), 64'd1);
`else
        check("m_ill", 64'(illegal), 64'd1);
        check("m_res", 64'(result), 64'd0);
`endif

        // illegal opcode
        drive(7'h7F, 3'd0, 7'h00, 32'h10, 32'h5, 32'h6, 32'h7, 1'b1);
        step();
        check("ill_flag", 64'(illegal), 64'd1);
        check("ill_strb", 64'({reg_write, alu_src, mem_read, mem_write, branch,
                               jump, jump_r, mem_to_reg, auipc}), 64'd0);

        // reset while in_valid=1, then recovery
        drive(7'h33, 3'd0, 7'h00, 32'd0, 32'd5, 32'd7, 32'd0, 1'b1);
        rst = 1'b1;
        step();
        check("rst_mid", 64'(obs), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst_idle", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        step();
        check("rst_first", 64'(result), 64'd12);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(rnd_op(), 3'($urandom), rnd_f7(), $urandom & 32'hFFFF_FFFC,
                  rnd_val(), rnd_val(), rnd_val(), $urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
